// File: rtl/button_conditioner.sv
// Input conditioning for the calculator front panel: every pushbutton and
// slide switch is synchronised with two flops and then debounced on its own.
// Buttons give a clean level plus one-cycle press and release pulses. Switches
// give a clean level plus a single change pulse shared by all switch bits.
module button_conditioner #(
  parameter int N_BTN              = 5,
  parameter int N_SW               = 5,
  parameter int DEBOUNCE_CYCLES    = 1000000,
  parameter int SW_DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_SW-1:0]  sw_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_SW-1:0]  sw_stable,
  output logic             sw_change
);

  // Each counter only has to reach HOLD-1, so clog2(HOLD) bits are enough
  // and the counter can never wrap.
  localparam int BTN_CW = $clog2(DEBOUNCE_CYCLES);
  localparam int SW_CW  = $clog2(SW_DEBOUNCE_CYCLES);
  localparam logic [BTN_CW-1:0] BTN_CNT_MAX = BTN_CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW_CW-1:0]  SW_CNT_MAX  = SW_CW'(SW_DEBOUNCE_CYCLES - 1);

  logic [N_SW-1:0] sw_update;
  logic            sw_change_reg;

  genvar gi;

  // Button channels.
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_btn
      logic              s1_reg;
      logic              s2_reg;
      logic              stable_reg;
      logic              press_reg;
      logic              release_reg;
      logic [BTN_CW-1:0] cnt_reg;

      // Two-flop synchroniser for the asynchronous raw button level.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s1_reg <= 1'b0;
          s2_reg <= 1'b0;
        end else begin
          s1_reg <= btn_raw[gi];
          s2_reg <= s1_reg;
        end
      end

      // Accept a new level only after it has held for DEBOUNCE_CYCLES cycles,
      // and fire the matching pulse in the same cycle the level flips.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          stable_reg  <= 1'b0;
          cnt_reg     <= '0;
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
        end else begin
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
          if (s2_reg == stable_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == BTN_CNT_MAX) begin
            stable_reg  <= s2_reg;
            cnt_reg     <= '0;
            press_reg   <= s2_reg;
            release_reg <= ~s2_reg;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign btn_level[gi]   = stable_reg;
      assign btn_press[gi]   = press_reg;
      assign btn_release[gi] = release_reg;
    end
  endgenerate

  // Switch channels.
  generate
    for (gi = 0; gi < N_SW; gi++) begin : g_sw
      logic             s1_reg;
      logic             s2_reg;
      logic             stable_reg;
      logic [SW_CW-1:0] cnt_reg;

      // Two-flop synchroniser for the asynchronous raw switch level.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s1_reg <= 1'b0;
          s2_reg <= 1'b0;
        end else begin
          s1_reg <= sw_raw[gi];
          s2_reg <= s1_reg;
        end
      end

      // The cycle in which this bit accepts its new value.
      assign sw_update[gi] = (s2_reg != stable_reg) && (cnt_reg == SW_CNT_MAX);

      // Same hold-then-accept rule as the buttons, using the switch hold time.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          stable_reg <= 1'b0;
          cnt_reg    <= '0;
        end else if (s2_reg == stable_reg) begin
          cnt_reg <= '0;
        end else if (sw_update[gi]) begin
          stable_reg <= s2_reg;
          cnt_reg    <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign sw_stable[gi] = stable_reg;
    end
  endgenerate

  // A single change pulse, however many switch bits update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_change_reg <= 1'b0;
    end else begin
      sw_change_reg <= |sw_update;
    end
  end

  assign sw_change = sw_change_reg;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with both hold times set to 4 cycles.
// The stimulus queues each expected pulse event (the cycle stamp and the
// full output state). A monitor compares every cycle that carries a pulse
// against the head of that queue.
module tb_button_conditioner;

  localparam int NB  = 5;
  localparam int NS  = 5;
  localparam int LAT = 6;   // drive at a negedge, pulse seen 6 cycles later

  logic          clk;
  logic          rst_n;
  logic [NB-1:0] btn_raw;
  logic [NS-1:0] sw_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic [NS-1:0] sw_stable;
  logic          sw_change;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int          at;
    logic [4:0]  press;
    logic [4:0]  rel;
    logic        chg;
    logic [4:0]  lvl;
    logic [4:0]  sw;
  } ev_t;

  ev_t exp_q[$];

  button_conditioner #(
    .N_BTN(NB),
    .N_SW(NS),
    .DEBOUNCE_CYCLES(4),
    .SW_DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .sw_raw(sw_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .sw_stable(sw_stable),
    .sw_change(sw_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_ev(input int dly, input logic [4:0] p, input logic [4:0] r,
                         input logic c, input logic [4:0] l, input logic [4:0] s);
    ev_t e;
    e.at = cyc + dly; e.press = p; e.rel = r; e.chg = c; e.lvl = l; e.sw = s;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".btn_level"}, int'(btn_level), 0);
    check({tag, ".btn_press"}, int'(btn_press), 0);
    check({tag, ".btn_release"}, int'(btn_release), 0);
    check({tag, ".sw_stable"}, int'(sw_stable), 0);
    check({tag, ".sw_change"}, int'(sw_change), 0);
  endtask

  // Monitor: any cycle with a pulse must match the next queued event.
  always @(negedge clk) begin
    if (rst_n && ((btn_press !== 5'd0) || (btn_release !== 5'd0) || (sw_change !== 1'b0))) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_event: cycle %0d press=%b release=%b sw_change=%b, expected no event",
                 cyc, btn_press, btn_release, sw_change);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("event_cycle", cyc, e.at);
        check("btn_press", int'(btn_press), int'(e.press));
        check("btn_release", int'(btn_release), int'(e.rel));
        check("sw_change", int'(sw_change), int'(e.chg));
        check("btn_level", int'(btn_level), int'(e.lvl));
        check("sw_stable", int'(sw_stable), int'(e.sw));
        $display("[TB] event at cycle %0d press=%b release=%b sw_change=%b level=%b sw=%b",
                 cyc, btn_press, btn_release, sw_change, btn_level, sw_stable);
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    btn_raw = 5'h1F;
    sw_raw  = 5'h1F;

    // Reset holds every output low even with all raw inputs high.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_all_zero("reset");
    end
    btn_raw = 5'd0;
    sw_raw  = 5'd0;
    rst_n   = 1'b1;
    wait_cyc(5);

    // Clean press and release on BTNU.
    btn_raw[0] = 1'b1;
    push_ev(LAT, 5'b00001, 5'b00000, 1'b0, 5'b00001, 5'b00000);
    wait_cyc(3);
    check("level_before_accept", int'(btn_level), 0);
    wait_cyc(17);
    btn_raw[0] = 1'b0;
    push_ev(LAT, 5'b00000, 5'b00001, 1'b0, 5'b00000, 5'b00000);
    wait_cyc(10);

    // Bounce on BTNL: 1,0,1,1,0,1 then held; only the final run is accepted.
    begin
      logic [5:0] pat;
      pat = 6'b101101;
      for (int k = 0; k < 6; k++) begin
        btn_raw[1] = pat[5-k];
        if (k == 5) push_ev(LAT, 5'b00010, 5'b00000, 1'b0, 5'b00010, 5'b00000);
        wait_cyc(1);
      end
    end
    wait_cyc(12);
    btn_raw[1] = 1'b0;
    push_ev(LAT, 5'b00000, 5'b00010, 1'b0, 5'b00000, 5'b00000);
    wait_cyc(10);

    // Two buttons rising together pulse in the same single cycle.
    btn_raw = 5'b00011;
    push_ev(LAT, 5'b00011, 5'b00000, 1'b0, 5'b00011, 5'b00000);
    wait_cyc(10);
    btn_raw = 5'b00000;
    push_ev(LAT, 5'b00000, 5'b00011, 1'b0, 5'b00000, 5'b00000);
    wait_cyc(10);

    // Three switch bits change together: one sw_change pulse.
    sw_raw = 5'b10101;
    push_ev(LAT, 5'b00000, 5'b00000, 1'b1, 5'b00000, 5'b10101);
    wait_cyc(10);

    // A 3-cycle glitch on sw[2] is rejected.
    sw_raw[2] = 1'b0;
    wait_cyc(3);
    sw_raw[2] = 1'b1;
    wait_cyc(10);
    check("sw_after_glitch", int'(sw_stable), 5'b10101);

    sw_raw = 5'b00000;
    push_ev(LAT, 5'b00000, 5'b00000, 1'b1, 5'b00000, 5'b00000);
    wait_cyc(10);

    // Reset in the middle of a BTNU debounce restarts the whole count.
    btn_raw[0] = 1'b1;
    push_ev(11, 5'b00001, 5'b00000, 1'b0, 5'b00001, 5'b00000);
    wait_cyc(4);
    rst_n = 1'b0;
    wait_cyc(1);
    check_all_zero("mid_reset");
    rst_n = 1'b1;
    wait_cyc(12);
    btn_raw[0] = 1'b0;
    push_ev(LAT, 5'b00000, 5'b00001, 1'b0, 5'b00000, 5'b00000);
    wait_cyc(10);

    check("events_left", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
